// File: rtl/netlist_bist_ctrl.sv
// Logic BIST controller: LFSR pattern source,
// MISR response compactor and run sequencer.
module netlist_bist_ctrl #(
  parameter int IN_W    = 39,
  parameter int PAT_CNT = 1024,
  parameter int SETTLE  = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            abort,
  input  logic [63:0]     seed,
  input  logic [15:0]     golden_sig,
  input  logic            dut_out,
  output logic [IN_W-1:0] dut_in,
  output logic            busy,
  output logic            done,
  output logic            pass,
  output logic [15:0]     signature,
  output logic [15:0]     pat_idx
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SEED,
    S_APPLY,
    S_WAIT,
    S_CAPTURE,
    S_FIN
  } state_e;

  localparam logic [15:0] PAT_LAST =
    16'(PAT_CNT - 1);
  localparam logic [3:0]  SET_LAST =
    4'(SETTLE - 1);
  localparam logic [63:0] LFSR_TAP = 64'h1B;
  localparam logic [15:0] MISR_TAP = 16'h1021;

  state_e      state_q;
  logic [63:0] lfsr_q;
  logic [63:0] lfsr_d;
  logic [63:0] seed_eff;
  logic [15:0] sig_q;
  logic [15:0] sig_d;
  logic        misr_fb;
  logic [15:0] idx_q;
  logic [3:0]  cnt_q;
  logic        busy_q;
  logic        done_q;
  logic        pass_q;

  // Next LFSR/MISR values and the zero-seed guard
  always_comb begin
    lfsr_d = {lfsr_q[62:0], 1'b0};
    if (lfsr_q[63]) begin
      lfsr_d = lfsr_d ^ LFSR_TAP;
    end
    misr_fb = sig_q[15] ^ dut_out;
    sig_d   = {sig_q[14:0], 1'b0};
    if (misr_fb) begin
      sig_d = sig_d ^ MISR_TAP;
    end
    seed_eff = seed;
    if (seed == 64'h0) begin
      seed_eff = 64'h1;
    end
  end

  // Run sequencer with registered status outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      lfsr_q  <= 64'h1;
      sig_q   <= 16'hFFFF;
      idx_q   <= 16'h0;
      cnt_q   <= 4'h0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (abort && (state_q != S_IDLE)) begin
        state_q <= S_IDLE;
        busy_q  <= 1'b0;
      end else begin
        case (state_q)
          S_IDLE: begin
            if (start && !abort) begin
              state_q <= S_SEED;
              busy_q  <= 1'b1;
            end
          end
          S_SEED: begin
            lfsr_q  <= seed_eff;
            sig_q   <= 16'hFFFF;
            idx_q   <= 16'h0;
            state_q <= S_APPLY;
          end
          S_APPLY: begin
            cnt_q <= 4'h0;
            if (SETTLE > 0) begin
              state_q <= S_WAIT;
            end else begin
              state_q <= S_CAPTURE;
            end
          end
          S_WAIT: begin
            if (cnt_q == SET_LAST) begin
              state_q <= S_CAPTURE;
            end else begin
              cnt_q <= cnt_q + 4'd1;
            end
          end
          S_CAPTURE: begin
            sig_q  <= sig_d;
            lfsr_q <= lfsr_d;
            if (idx_q == PAT_LAST) begin
              state_q <= S_FIN;
            end else begin
              idx_q   <= idx_q + 16'd1;
              state_q <= S_APPLY;
            end
          end
          S_FIN: begin
            done_q  <= 1'b1;
            pass_q  <= (sig_q == golden_sig);
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end
          default: begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign dut_in    = lfsr_q[IN_W-1:0];
  assign busy      = busy_q;
  assign done      = done_q;
  assign pass      = pass_q;
  assign signature = sig_q;
  assign pat_idx   = idx_q;

endmodule

// File: tb/tb_netlist_bist_ctrl.sv
// Directed bench for netlist_bist_ctrl:
// three instances cover the parameter corners.
module tb_netlist_bist_ctrl;

  logic clk;
  logic rst_n;

  logic        st_a, ab_a, do_a;
  logic [63:0] seed_a;
  logic [15:0] gold_a;
  logic [38:0] din_a;
  logic        busy_a, done_a, pass_a;
  logic [15:0] sig_a, idx_a;

  logic        st_b, ab_b, do_b;
  logic [63:0] seed_b;
  logic [15:0] gold_b;
  logic [63:0] din_b;
  logic        busy_b, done_b, pass_b;
  logic [15:0] sig_b, idx_b;

  logic        st_c, ab_c, do_c;
  logic [63:0] seed_c;
  logic [15:0] gold_c;
  logic [7:0]  din_c;
  logic        busy_c, done_c, pass_c;
  logic [15:0] sig_c, idx_c;

  int checks;
  int errors;

  netlist_bist_ctrl #(
    .IN_W(39), .PAT_CNT(4), .SETTLE(0)
  ) u_a (
    .clk(clk), .rst_n(rst_n),
    .start(st_a), .abort(ab_a),
    .seed(seed_a), .golden_sig(gold_a),
    .dut_out(do_a), .dut_in(din_a),
    .busy(busy_a), .done(done_a),
    .pass(pass_a), .signature(sig_a),
    .pat_idx(idx_a)
  );

  netlist_bist_ctrl #(
    .IN_W(64), .PAT_CNT(4), .SETTLE(3)
  ) u_b (
    .clk(clk), .rst_n(rst_n),
    .start(st_b), .abort(ab_b),
    .seed(seed_b), .golden_sig(gold_b),
    .dut_out(do_b), .dut_in(din_b),
    .busy(busy_b), .done(done_b),
    .pass(pass_b), .signature(sig_b),
    .pat_idx(idx_b)
  );

  netlist_bist_ctrl #(
    .IN_W(8), .PAT_CNT(1), .SETTLE(1)
  ) u_c (
    .clk(clk), .rst_n(rst_n),
    .start(st_c), .abort(ab_c),
    .seed(seed_c), .golden_sig(gold_c),
    .dut_out(do_c), .dut_in(din_c),
    .busy(busy_c), .done(done_c),
    .pass(pass_c), .signature(sig_c),
    .pat_idx(idx_c)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    checks++;
    if ({busy_a, done_a, pass_a} !== 3'b000) begin
      errors++;
      $display("FAIL rst_flags_a got %b want 000",
               {busy_a, done_a, pass_a});
    end
    checks++;
    if (din_a !== 39'd1 || sig_a !== 16'hFFFF) begin
      errors++;
      $display("FAIL rst_lfsr_misr_a got %h/%h want 1/ffff",
               din_a, sig_a);
    end
    checks++;
    if (idx_b !== 16'h0 || din_b !== 64'h1) begin
      errors++;
      $display("FAIL rst_b got idx %h din %h want 0/1",
               idx_b, din_b);
    end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_basic_pass();
    int done_at;
    int ndone;
    logic [38:0] exp;
    seed_a = 64'h1;
    gold_a = 16'h0E1F;
    do_a   = 1'b0;
    st_a   = 1'b1;
    tick();
    st_a    = 1'b0;
    done_at = -1;
    ndone   = 0;
    for (int c = 1; c <= 20; c++) begin
      tick();
      if (done_a) begin
        ndone++;
        if (done_at < 0) done_at = c;
      end
      if (c == 1 || c == 3 || c == 5 || c == 7) begin
        exp = 39'd1 << ((c - 1) / 2);
        checks++;
        if (din_a !== exp || idx_a !== 16'((c - 1) / 2)) begin
          errors++;
          $display("FAIL pattern_a c=%0d got %h idx %0d want %h",
                   c, din_a, idx_a, exp);
        end
      end
      if (c == 9) begin
        checks++;
        if (busy_a !== 1'b1) begin
          errors++;
          $display("FAIL busy_fin got %b want 1", busy_a);
        end
      end
      if (c == 10) begin
        checks++;
        if (busy_a !== 1'b0) begin
          errors++;
          $display("FAIL busy_after got %b want 0", busy_a);
        end
      end
    end
    checks++;
    if (done_at != 10 || ndone != 1) begin
      errors++;
      $display("FAIL done_lat_a got %0d x%0d want 10 x1",
               done_at, ndone);
    end
    checks++;
    if (sig_a !== 16'h0E1F || pass_a !== 1'b1) begin
      errors++;
      $display("FAIL sig_pass_a got %h/%b want 0e1f/1",
               sig_a, pass_a);
    end
  endtask

  task automatic test_golden_miss();
    int ndone;
    gold_a = 16'h0000;
    st_a   = 1'b1;
    tick();
    st_a  = 1'b0;
    ndone = 0;
    for (int c = 1; c <= 20; c++) begin
      tick();
      if (done_a) ndone++;
    end
    checks++;
    if (sig_a !== 16'h0E1F || pass_a !== 1'b0 ||
        ndone != 1) begin
      errors++;
      $display("FAIL miss_a got %h/%b x%0d want 0e1f/0 x1",
               sig_a, pass_a, ndone);
    end
  endtask

  task automatic test_abort();
    int ndone;
    int done_at;
    gold_a = 16'h0E1F;
    st_a   = 1'b1;
    tick();
    st_a = 1'b0;
    for (int c = 1; c <= 5; c++) tick();
    ab_a = 1'b1;
    tick();
    ab_a = 1'b0;
    checks++;
    if (busy_a !== 1'b0 || idx_a !== 16'd2 ||
        sig_a !== 16'hCF9F || pass_a !== 1'b0) begin
      errors++;
      $display("FAIL abort_hold got b%b i%0d s%h p%b want 0/2/cf9f/0",
               busy_a, idx_a, sig_a, pass_a);
    end
    ndone = 0;
    for (int c = 1; c <= 15; c++) begin
      tick();
      if (done_a || busy_a) ndone++;
    end
    checks++;
    if (ndone != 0 || pass_a !== 1'b0) begin
      errors++;
      $display("FAIL abort_quiet got %0d/%b want 0/0",
               ndone, pass_a);
    end
    st_a = 1'b1;
    tick();
    st_a    = 1'b0;
    done_at = -1;
    for (int c = 1; c <= 15; c++) begin
      tick();
      if (done_a && done_at < 0) done_at = c;
    end
    checks++;
    if (done_at != 10 || sig_a !== 16'h0E1F ||
        pass_a !== 1'b1) begin
      errors++;
      $display("FAIL rerun got %0d/%h/%b want 10/0e1f/1",
               done_at, sig_a, pass_a);
    end
  endtask

  task automatic test_idle_abort();
    st_a = 1'b1;
    ab_a = 1'b1;
    tick();
    st_a = 1'b0;
    ab_a = 1'b0;
    checks++;
    if (busy_a !== 1'b0 || pass_a !== 1'b1 ||
        sig_a !== 16'h0E1F) begin
      errors++;
      $display("FAIL idle_abort got %b/%b/%h want 0/1/0e1f",
               busy_a, pass_a, sig_a);
    end
    tick();
    checks++;
    if (busy_a !== 1'b0) begin
      errors++;
      $display("FAIL idle_abort2 got %b want 0", busy_a);
    end
  endtask

  task automatic test_start_held_reset();
    int ndone;
    int done_at;
    st_a = 1'b1;
    tick();
    ndone   = 0;
    done_at = -1;
    for (int c = 1; c <= 14; c++) begin
      tick();
      if (done_a) begin
        ndone++;
        if (done_at < 0) done_at = c;
      end
      if (c == 3) begin
        checks++;
        if (din_a !== 39'd2) begin
          errors++;
          $display("FAIL held_pat got %h want 2", din_a);
        end
      end
      if (c == 10) begin
        checks++;
        if (busy_a !== 1'b0) begin
          errors++;
          $display("FAIL held_idle got %b want 0", busy_a);
        end
      end
    end
    checks++;
    if (done_at != 10 || ndone != 1) begin
      errors++;
      $display("FAIL held_done got %0d x%0d want 10 x1",
               done_at, ndone);
    end
    #3;
    rst_n = 1'b0;
    #1;
    checks++;
    if (busy_a !== 1'b0 || din_a !== 39'd1 ||
        sig_a !== 16'hFFFF || pass_a !== 1'b0 ||
        idx_a !== 16'd0) begin
      errors++;
      $display("FAIL async_rst got b%b d%h s%h p%b i%0d",
               busy_a, din_a, sig_a, pass_a, idx_a);
    end
    #2;
    rst_n = 1'b1;
    tick();
    st_a = 1'b0;
    checks++;
    if (busy_a !== 1'b1) begin
      errors++;
      $display("FAIL first_edge got %b want 1", busy_a);
    end
    done_at = -1;
    for (int c = 1; c <= 15; c++) begin
      tick();
      if (done_a && done_at < 0) done_at = c;
    end
    checks++;
    if (done_at != 10 || pass_a !== 1'b1) begin
      errors++;
      $display("FAIL post_rst got %0d/%b want 10/1",
               done_at, pass_a);
    end
  endtask

  task automatic test_settle_zero_seed();
    int done_at;
    logic [63:0] exp;
    seed_b = 64'h0;
    gold_b = 16'h0E1F;
    do_b   = 1'b0;
    st_b   = 1'b1;
    tick();
    st_b    = 1'b0;
    done_at = -1;
    for (int c = 1; c <= 30; c++) begin
      tick();
      if (done_b && done_at < 0) done_at = c;
      if (c <= 20 && (c % 5 == 1 || c % 5 == 0)) begin
        exp = 64'd1 << ((c - 1) / 5);
        checks++;
        if (din_b !== exp) begin
          errors++;
          $display("FAIL hold_b c=%0d got %h want %h",
                   c, din_b, exp);
        end
      end
    end
    checks++;
    if (done_at != 22 || sig_b !== 16'h0E1F ||
        pass_b !== 1'b1) begin
      errors++;
      $display("FAIL settle_b got %0d/%h/%b want 22/0e1f/1",
               done_at, sig_b, pass_b);
    end
  endtask

  task automatic test_tap_wrap();
    seed_b = 64'h8000_0000_0000_0000;
    st_b   = 1'b1;
    tick();
    st_b = 1'b0;
    tick();
    checks++;
    if (din_b !== 64'h8000_0000_0000_0000) begin
      errors++;
      $display("FAIL wrap_p0 got %h want 8000000000000000",
               din_b);
    end
    for (int c = 2; c <= 6; c++) tick();
    checks++;
    if (din_b !== 64'h1B) begin
      errors++;
      $display("FAIL wrap_p1 got %h want 1b", din_b);
    end
    for (int c = 7; c <= 11; c++) tick();
    checks++;
    if (din_b !== 64'h36) begin
      errors++;
      $display("FAIL wrap_p2 got %h want 36", din_b);
    end
    for (int c = 12; c <= 25; c++) tick();
  endtask

  task automatic test_single_pattern();
    int done_at;
    int ndone;
    seed_c = 64'h1A5;
    gold_c = 16'hFFFE;
    do_c   = 1'b1;
    st_c   = 1'b1;
    tick();
    st_c    = 1'b0;
    done_at = -1;
    ndone   = 0;
    for (int c = 1; c <= 12; c++) begin
      tick();
      if (done_c) begin
        ndone++;
        if (done_at < 0) done_at = c;
      end
      if (c == 1) begin
        checks++;
        if (din_c !== 8'hA5) begin
          errors++;
          $display("FAIL single_pat got %h want a5", din_c);
        end
      end
    end
    checks++;
    if (done_at != 5 || ndone != 1 ||
        sig_c !== 16'hFFFE || pass_c !== 1'b1 ||
        idx_c !== 16'd0) begin
      errors++;
      $display("FAIL single got %0d x%0d %h %b %0d",
               done_at, ndone, sig_c, pass_c, idx_c);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    st_a = 1'b0; ab_a = 1'b0; do_a = 1'b0;
    seed_a = '0; gold_a = '0;
    st_b = 1'b0; ab_b = 1'b0; do_b = 1'b0;
    seed_b = '0; gold_b = '0;
    st_c = 1'b0; ab_c = 1'b0; do_c = 1'b0;
    seed_c = '0; gold_c = '0;
    test_reset();
    test_basic_pass();
    test_golden_miss();
    test_abort();
    test_idle_abort();
    test_start_held_reset();
    test_settle_zero_seed();
    test_tap_wrap();
    test_single_pattern();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/netlist_bist_ctrl.md
NETLIST_BIST_CTRL -- requirements
Module: netlist_bist_ctrl

Interface
REQ-001 Parameter IN_W, default 39: DUT primary-input width, legal range 1..64.
REQ-002 Parameter PAT_CNT, default 1024: patterns per run, legal range 1..65535.
REQ-003 Parameter SETTLE, default 2: idle cycles between applying a pattern and sampling the DUT output, legal range 0..15.
REQ-004 Port clk, input, 1: sole clock; all state updates on the rising edge.
REQ-005 Port rst_n, input, 1: reset, asynchronous, active-low.
REQ-006 Port start, input, 1: begin a run when sampled high in IDLE.
REQ-007 Port abort, input, 1: cancel the run in progress.
REQ-008 Port seed, input, 64: initial pattern-generator value.
REQ-009 Port golden_sig, input, 16: expected signature.
REQ-010 Port dut_out, input, 1: DUT primary output.
REQ-011 Port dut_in, output, IN_W: stimulus to the DUT primary inputs.
REQ-012 Port busy, output, 1: high in every state except IDLE.
REQ-013 Port done, output, 1: single-cycle completion pulse.
REQ-014 Port pass, output, 1: result of the last completed run.
REQ-015 Port signature, output, 16: current MISR value.
REQ-016 Port pat_idx, output, 16: index of the pattern currently being applied.

Function
REQ-017 FSM states SHALL be IDLE, SEED, APPLY, WAIT, CAPTURE and FIN.
REQ-018 IDLE SHALL move to SEED when start=1; start SHALL be ignored in every other state.
REQ-019 SEED (1 cycle) SHALL load lfsr with seed, or with 64'h1 when seed==0, load signature with 16'hFFFF and pat_idx with 0, then go to APPLY.
REQ-020 APPLY (1 cycle) SHALL go to WAIT when SETTLE>0, else to CAPTURE.
REQ-021 WAIT SHALL last exactly SETTLE cycles, counted by a 4-bit counter, then go to CAPTURE.
REQ-022 CAPTURE (1 cycle) SHALL update the MISR with dut_out and advance the lfsr.
REQ-023 CAPTURE SHALL go to FIN when pat_idx==PAT_CNT-1, else increment pat_idx and return to APPLY.
REQ-024 FIN (1 cycle) SHALL assert done, register pass=(signature==golden_sig), then go to IDLE.
REQ-025 dut_in SHALL equal lfsr[IN_W-1:0] continuously; lfsr SHALL change only in SEED and CAPTURE.
REQ-026 LFSR step: next = {lfsr[62:0],1'b0} XOR (lfsr[63] ? 64'h1B : 0).
REQ-027 MISR step: fb = signature[15] XOR dut_out; next = {signature[14:0],1'b0} XOR (fb ? 16'h1021 : 0).
REQ-028 Run latency: done SHALL be high exactly 2 + PAT_CNT*(SETTLE+2) cycles after the edge that samples start.
REQ-029 abort=1 in any non-IDLE state SHALL force IDLE on the next edge; done SHALL NOT pulse; pass, signature and pat_idx SHALL hold their values.
REQ-030 abort SHALL take priority over every other transition; abort in IDLE SHALL have no effect, and start and abort sampled together in IDLE SHALL leave the block in IDLE.
REQ-031 pass SHALL change only in FIN or on reset.
REQ-032 PAT_CNT=1 SHALL run exactly one APPLY/WAIT/CAPTURE sequence.

Reset
REQ-033 rst_n=0 SHALL immediately force IDLE and clear busy, done, pass, pat_idx and the WAIT counter.
REQ-034 rst_n=0 SHALL set lfsr=64'h1, so dut_in=1, and signature=16'hFFFF.
REQ-035 Assertion of rst_n mid-run SHALL abandon the run without a done pulse.
REQ-036 After release the block SHALL accept start on the first rising edge at which rst_n is high.

Verification
REQ-037 Scenario: IN_W=39, PAT_CNT=4, SETTLE=0, seed=1, dut_out=0, golden_sig=16'h0E1F, pulse start -> dut_in is 1,2,4,8 in successive patterns; done pulses 10 cycles after the start edge; signature=16'h0E1F; pass=1.
REQ-038 Scenario: same as REQ-037 with golden_sig=16'h0000 -> signature=16'h0E1F, pass=0, done pulses once.
REQ-039 Scenario: PAT_CNT=4, SETTLE=3, seed=0 -> first dut_in=1; each pattern is held for 5 cycles; done at cycle 22.
REQ-040 Scenario: abort during pattern 2 -> busy low next cycle; no done pulse; pass keeps its prior value; a following start runs to completion with the correct signature.
REQ-041 Scenario: start held high throughout a run, plus rst_n pulsed low mid-run -> no re-trigger while busy; reset forces dut_in=1, signature=16'hFFFF, busy=0 asynchronously.
REQ-042 Scenario: seed=64'h8000_0000_0000_0000, IN_W=64 -> second pattern 64'h1B (tap wrap-around).
